// File: rtl/heat_viz_pkg.sv
// heat_viz_pkg: 5.27 fixed-point thresholds, RGB332 palette and writer states for the heat visualiser.
package heat_viz_pkg;
    localparam int FRAC_W = 27;
    localparam int ONE = 1 << FRAC_W;
    localparam int TH_P6 = 6 * ONE;
    localparam int TH_P4 = 4 * ONE;
    localparam int TH_P2 = 2 * ONE;
    localparam int TH_Z = 0;
    localparam int TH_N2 = -2 * ONE;
    localparam int TH_N4 = -4 * ONE;
    localparam int TH_N6 = -6 * ONE;
    localparam logic [7:0] PAL_P6 = 8'hE0;
    localparam logic [7:0] PAL_P4 = 8'hE8;
    localparam logic [7:0] PAL_P2 = 8'hCD;
    localparam logic [7:0] PAL_Z = 8'hFF;
    localparam logic [7:0] PAL_N2 = 8'h77;
    localparam logic [7:0] PAL_N4 = 8'hF8;
    localparam logic [7:0] PAL_N6 = 8'hE3;
    localparam logic [7:0] PAL_LO = 8'h00;
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, FINISH} state_t;
endpackage

// File: rtl/heat_row_writer_if.sv
// heat_row_writer_if: frame-buffer write port; the writer is master, the M10K side is slave.
interface heat_row_writer_if #(parameter int ADDR_W = 12);
    logic wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0] wr_data;
    modport master (output wr_en, wr_addr, wr_data);
    modport slave (input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/heat_color_map.sv
// heat_color_map: combinational node value + mode to RGB332 pixel (palette or offset-binary grayscale).
module heat_color_map
    import heat_viz_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] v,
    input  logic              mode,
    output logic [7:0]        pix
);
    localparam logic signed [DATA_W-1:0] T_P6 = DATA_W'(TH_P6);
    localparam logic signed [DATA_W-1:0] T_P4 = DATA_W'(TH_P4);
    localparam logic signed [DATA_W-1:0] T_P2 = DATA_W'(TH_P2);
    localparam logic signed [DATA_W-1:0] T_Z = DATA_W'(TH_Z);
    localparam logic signed [DATA_W-1:0] T_N2 = DATA_W'(TH_N2);
    localparam logic signed [DATA_W-1:0] T_N4 = DATA_W'(TH_N4);
    localparam logic signed [DATA_W-1:0] T_N6 = DATA_W'(TH_N6);
    logic signed [DATA_W-1:0] s;
    logic [7:0] pal;
    always_comb begin
        s = $signed(v);
        pal = s >= T_P6 ? PAL_P6 :
              s >= T_P4 ? PAL_P4 :
              s >= T_P2 ? PAL_P2 :
              s >= T_Z  ? PAL_Z  :
              s >= T_N2 ? PAL_N2 :
              s >= T_N4 ? PAL_N4 :
              s >= T_N6 ? PAL_N6 : PAL_LO;
        pix = mode ? {~v[DATA_W-1], v[DATA_W-2 -: 7]} : pal;
    end
endmodule

// File: rtl/heat_row_writer.sv
// heat_row_writer: snapshots a row of node values on step_done and streams RGB332 pixels
// into the frame buffer at row-major addresses; also clears the whole frame on request.
module heat_row_writer
    import heat_viz_pkg::*;
#(
    parameter int NCOLS = 64,
    parameter int NROWS = 64,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(NCOLS * NROWS)
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic                       step_done,
    input  logic [NCOLS*DATA_W-1:0]    node_flat,
    input  logic                       mode,
    input  logic                       frame_clear,
    heat_row_writer_if.master          fb,
    output logic                       busy,
    output logic                       frame_done,
    output logic [$clog2(NROWS)-1:0]   row_idx,
    output logic                       overrun
);
    localparam int CW = $clog2(NCOLS);
    localparam int RW = $clog2(NROWS);
    localparam logic [ADDR_W-1:0] NC = ADDR_W'(NCOLS);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NCOLS - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NCOLS * NROWS - 1);

    state_t state, state_n;
    logic [DATA_W-1:0] snap [NCOLS];
    logic [ADDR_W-1:0] cnt;
    logic [7:0] pix;
    logic mode_q, was_clear, last, take_step, take_clear, drop;

    heat_color_map #(.DATA_W(DATA_W)) u_map (
        .v    (snap[cnt[CW-1:0]]),
        .mode (mode_q),
        .pix  (pix)
    );

    always_comb begin
        last = cnt == (state == CLEAR ? LAST_PIX : LAST_COL);
        take_clear = state == IDLE && frame_clear;
        take_step = state == IDLE && step_done && !frame_clear;
        drop = state == IDLE ? step_done && frame_clear : step_done || frame_clear;
        state_n = take_clear ? CLEAR :
                  take_step ? WRITE :
                  state == FINISH ? IDLE :
                  (state == WRITE || state == CLEAR) && last ? FINISH : state;
    end

    always_ff @(posedge clk_50) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end

    // Outputs are registered from the current state, so each write lands one cycle after its state.
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            fb.wr_en <= 1'b0;
            fb.wr_addr <= '0;
            fb.wr_data <= '0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            overrun <= 1'b0;
            row_idx <= '0;
            cnt <= '0;
            mode_q <= 1'b0;
            was_clear <= 1'b0;
        end else begin
            fb.wr_en <= state == WRITE || state == CLEAR;
            fb.wr_addr <= state == WRITE ? ADDR_W'(row_idx) * NC + cnt : state == CLEAR ? cnt : '0;
            fb.wr_data <= state == WRITE ? pix : 8'h00;
            busy <= state != IDLE;
            frame_done <= state == FINISH;
            overrun <= overrun | drop;
            cnt <= take_step || take_clear ? '0 : cnt + 1'b1;
            was_clear <= take_clear ? 1'b1 : take_step ? 1'b0 : was_clear;
            mode_q <= take_step ? mode : mode_q;
            // Row pointer advances as frame_done drops, i.e. in step with busy falling.
            row_idx <= state == CLEAR && last ? '0 :
                       frame_done && !was_clear ? (row_idx == RW'(NROWS - 1) ? '0 : row_idx + 1'b1) :
                       row_idx;
            if (take_step)
                for (int c = 0; c < NCOLS; c++) snap[c] <= node_flat[c*DATA_W +: DATA_W];
        end
    end
endmodule

// File: tb/tb_heat_row_writer.sv
// tb_heat_row_writer: directed vectors for palette, grayscale, thresholds, wrap, overrun, clear and reset.
module tb_heat_row_writer;
    localparam int NC = 8;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk_50 = 1'b0;
    logic reset, step_done, mode, frame_clear;
    logic [NC*DW-1:0] node_flat;
    logic busy, frame_done, overrun;
    logic [1:0] row_idx;
    logic [31:0] vals [NC];
    logic [7:0] exps [NC];
    int n_vec = 0;
    int n_err = 0;

    heat_row_writer_if #(.ADDR_W(AW)) fb ();

    heat_row_writer #(.NCOLS(NC), .NROWS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .step_done   (step_done),
        .node_flat   (node_flat),
        .mode        (mode),
        .frame_clear (frame_clear),
        .fb          (fb),
        .busy        (busy),
        .frame_done  (frame_done),
        .row_idx     (row_idx),
        .overrun     (overrun)
    );

    always #5 clk_50 = ~clk_50;

    function automatic logic [31:0] fx(input real r);
        return 32'($rtoi(r * 134217728.0));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pack();
        for (int c = 0; c < NC; c++) node_flat[c*DW +: DW] = vals[c];
    endtask

    task automatic set_a();
        vals = '{fx(7.0), fx(5.0), fx(3.0), fx(0.5), fx(-1.0), fx(-3.0), fx(-5.0), fx(-7.0)};
        exps = '{8'hE0, 8'hE8, 8'hCD, 8'hFF, 8'h77, 8'hF8, 8'hE3, 8'h00};
    endtask

    task automatic set_b();
        vals = '{32'h0, fx(6.0), 32'h8000_0000, 32'h7FFF_FFFF, fx(-1.0), fx(1.5), fx(-0.5), fx(15.0)};
        exps = '{8'h80, 8'hB0, 8'h00, 8'hFF, 8'h78, 8'h8C, 8'h7C, 8'hF8};
    endtask

    task automatic set_c();
        vals = '{fx(2.0), fx(-6.0), fx(6.0), fx(4.0), 32'h0, fx(-2.0), fx(-4.0), 32'hCFFF_FFFF};
        exps = '{8'hCD, 8'hE3, 8'hE0, 8'hE8, 8'hFF, 8'h77, 8'hF8, 8'h00};
    endtask

    // Returns just after the frame_done edge, so the next step_done lands on the earliest accepting edge.
    task automatic run_row(input logic m, input int row, input bit interfere);
        pack();
        mode = m;
        step_done = 1'b1;
        @(posedge clk_50);
        #1 step_done = 1'b0;
        check("row_idx at capture", row_idx, row);
        for (int c = 0; c < NC; c++) begin
            @(posedge clk_50);
            #1;
            check("wr_en", fb.wr_en, 1);
            check("wr_addr", fb.wr_addr, row * NC + c);
            check("wr_data", fb.wr_data, exps[c]);
            check("busy", busy, 1);
            if (interfere && c == 1) begin
                step_done = 1'b1;
                node_flat = ~node_flat;
                mode = ~m;
            end
            if (interfere && c == 2) begin
                step_done = 1'b0;
                pack();
                mode = m;
            end
        end
        @(posedge clk_50);
        #1;
        check("wr_en after row", fb.wr_en, 0);
        check("frame_done", frame_done, 1);
    endtask

    task automatic run_clear(input bit with_step);
        set_a();
        pack();
        frame_clear = 1'b1;
        step_done = with_step;
        @(posedge clk_50);
        #1;
        frame_clear = 1'b0;
        step_done = 1'b0;
        for (int i = 0; i < NC * NR; i++) begin
            @(posedge clk_50);
            #1;
            check("clear wr_en", fb.wr_en, 1);
            check("clear wr_addr", fb.wr_addr, i);
            check("clear wr_data", fb.wr_data, 0);
        end
        @(posedge clk_50);
        #1;
        check("clear end wr_en", fb.wr_en, 0);
        check("clear frame_done", frame_done, 1);
        check("clear row_idx", row_idx, 0);
    endtask

    initial begin
        reset = 1'b0;
        step_done = 1'b0;
        frame_clear = 1'b0;
        mode = 1'b0;
        node_flat = '0;
        repeat (3) @(posedge clk_50);
        #1;
        check("reset wr_en", fb.wr_en, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        check("reset overrun", overrun, 0);
        check("reset row_idx", row_idx, 0);
        check("reset wr_addr", fb.wr_addr, 0);
        check("reset wr_data", fb.wr_data, 0);
        reset = 1'b1;

        set_a(); run_row(1'b0, 0, 1'b0);
        set_b(); run_row(1'b1, 1, 1'b0);
        set_c(); run_row(1'b0, 2, 1'b0);
        set_a(); run_row(1'b0, 3, 1'b0);
        set_b(); run_row(1'b1, 0, 1'b0);
        @(posedge clk_50);
        #1;
        check("wrap row_idx", row_idx, 1);
        check("idle busy", busy, 0);
        check("idle frame_done", frame_done, 0);
        check("no overrun yet", overrun, 0);

        set_c(); run_row(1'b0, 1, 1'b1);
        check("overrun set", overrun, 1);
        @(posedge clk_50);
        #1 check("row_idx after overrun row", row_idx, 2);

        run_clear(1'b0);
        check("overrun sticky", overrun, 1);

        set_a();
        pack();
        mode = 1'b0;
        step_done = 1'b1;
        @(posedge clk_50);
        #1 step_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_50);
            #1 check("pre-reset wr_data", fb.wr_data, exps[c]);
        end
        reset = 1'b0;
        @(posedge clk_50);
        #1;
        check("mid reset wr_en", fb.wr_en, 0);
        check("mid reset busy", busy, 0);
        check("mid reset overrun", overrun, 0);
        check("mid reset wr_addr", fb.wr_addr, 0);
        check("mid reset wr_data", fb.wr_data, 0);
        check("mid reset row_idx", row_idx, 0);
        reset = 1'b1;
        set_b(); run_row(1'b1, 0, 1'b0);
        @(posedge clk_50);
        #1;
        check("row_idx after reset row", row_idx, 1);
        check("overrun before combo", overrun, 0);

        run_clear(1'b1);
        check("combo overrun", overrun, 1);
        @(posedge clk_50);
        #1;
        check("combo idle busy", busy, 0);
        check("combo idle wr_en", fb.wr_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
